// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access, with a watchdog timeout.
// Optional build macro MEM_ARB_RR_EN: alternate the winner when both requesters contend.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic [3:0]    d_wea,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          err,
  output logic          m_req,
  output logic [AW-1:0] m_addr,
  output logic [3:0]    m_wea,
  output logic [31:0]   m_wdata,
  input  logic          m_gnt,
  input  logic          m_rvalid,
  input  logic [31:0]   m_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          m_req_q, m_req_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [3:0]    m_wea_q, m_wea_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          err_q, err_d;
  logic [15:0]   wdog_q, wdog_d;
  logic          pick_data, done, tmo, wdog_hit;
  logic [31:0]   resp_data;
`ifdef MEM_ARB_RR_EN
  owner_e        last_owner_q, last_owner_d;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= FETCH;
      m_req_q    <= 1'b0;
      m_addr_q   <= '0;
      m_wea_q    <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      wdog_q     <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= DATA;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      m_req_q    <= m_req_d;
      m_addr_q   <= m_addr_d;
      m_wea_q    <= m_wea_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    done     = 1'b0;
    tmo      = 1'b0;
    // Fires in the TIMEOUT-th cycle spent in ISSUE+WAIT
    wdog_hit = ({1'b0, wdog_q} + 17'd1) == 17'(TIMEOUT);
`ifdef MEM_ARB_RR_EN
    pick_data    = d_req && (!if_req || (last_owner_q == FETCH));
    last_owner_d = (state_q == RESP) ? owner_q : last_owner_q;
`else
    pick_data    = d_req;
`endif
    case (state_q)
      IDLE: begin
        if (d_req || if_req) begin
          owner_d = pick_data ? DATA : FETCH;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_gnt && m_rvalid) begin
          done    = 1'b1;
          state_d = RESP;
        end else if (wdog_hit) begin
          tmo     = 1'b1;
          state_d = RESP;
        end else if (m_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (m_rvalid) begin
          done    = 1'b1;
          state_d = RESP;
        end else if (wdog_hit) begin
          tmo     = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered output logic
  always_comb begin
    m_req_d    = m_req_q;
    m_addr_d   = m_addr_q;
    m_wea_d    = m_wea_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    err_d      = 1'b0;
    wdog_d     = wdog_q;
    resp_data  = tmo ? '0 : m_rdata;
    case (state_q)
      IDLE: begin
        if (state_d == ISSUE) begin
          m_req_d = 1'b1;
          wdog_d  = '0;
          if (owner_d == DATA) begin
            m_addr_d  = d_addr;
            m_wea_d   = d_wea;
            m_wdata_d = d_wdata;
          end else begin
            m_addr_d  = if_addr;
            m_wea_d   = '0;
            m_wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        wdog_d = wdog_q + 16'd1;
        if (m_gnt || tmo) m_req_d = 1'b0;
      end
      WAIT:    wdog_d = wdog_q + 16'd1;
      default: ;
    endcase
    if (done || tmo) begin
      err_d = tmo;
      if (owner_q == DATA) begin
        d_ack_d   = 1'b1;
        d_rdata_d = resp_data;
      end else begin
        if_ack_d   = 1'b1;
        if_rdata_d = resp_data;
      end
    end
  end

  assign m_req    = m_req_q;
  assign m_addr   = m_addr_q;
  assign m_wea    = m_wea_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT overridden to 8).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic [3:0]  d_wea;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        m_req;
  logic [31:0] m_addr;
  logic [3:0]  m_wea;
  logic [31:0] m_wdata;
  logic        m_gnt;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mem_port_arbiter #(.TIMEOUT(8), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_wea(d_wea), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .m_req(m_req), .m_addr(m_addr), .m_wea(m_wea), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: entered with m_req visible, returns with the ack visible.
  task automatic mem_serve(input int unsigned gnt_wait, input logic same_cycle,
                           input logic [31:0] addr, input logic [31:0] rdata);
    for (int unsigned i = 0; i < gnt_wait; i++) begin
      check("wait_req", m_req, 1);
      check("wait_addr", m_addr, addr);
      tick();
    end
    check("gnt_req", m_req, 1);
    check("gnt_addr", m_addr, addr);
    m_gnt = 1'b1;
    if (same_cycle) begin
      m_rvalid = 1'b1;
      m_rdata  = rdata;
    end
    tick();
    m_gnt    = 1'b0;
    m_rvalid = 1'b0;
    if (!same_cycle) begin
      check("gnt_drop", m_req, 0);
      m_rvalid = 1'b1;
      m_rdata  = rdata;
      tick();
      m_rvalid = 1'b0;
    end
    check("resp_req", m_req, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mreq"}, m_req, 0);
    check({tag, "_maddr"}, m_addr, 0);
    check({tag, "_mwea"}, m_wea, 0);
    check({tag, "_mwdata"}, m_wdata, 0);
    check({tag, "_ifrd"}, if_rdata, 0);
    check({tag, "_drd"}, d_rdata, 0);
    check({tag, "_acks"}, {if_ack, d_ack, err, busy}, 0);
  endtask

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wea = '0;
    d_addr = '0; d_wdata = '0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    check_all_zero("reset");

    // Fetch-only read with zero-wait memory
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    check("f_busy", busy, 1);
    check("f_wea", m_wea, 0);
    mem_serve(0, 1'b0, 32'h100, 32'h0050_0093);
    check("f_ack", if_ack, 1);
    check("f_rdata", if_rdata, 32'h0050_0093);
    check("f_err", err, 0);
    check("f_dack", d_ack, 0);
    if_req = 1'b0;
    tick();
    check("f_ack_pulse", if_ack, 0);
    check("f_idle", busy, 0);
    check("f_rdata_hold", if_rdata, 32'h0050_0093);

    // Contention round A: data wins in both builds (last owner was fetch)
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_wea = 4'b0011; d_addr = 32'h200; d_wdata = 32'hBEEF;
    tick();
    check("ca_wea", m_wea, 4'b0011);
    check("ca_wdata", m_wdata, 32'hBEEF);
    mem_serve(0, 1'b0, 32'h200, 32'hDEAD_0001);
    check("ca_dack", d_ack, 1);
    check("ca_ifack", if_ack, 0);
    check("ca_drdata", d_rdata, 32'hDEAD_0001);
    check("ca_ifrd_hold", if_rdata, 32'h0050_0093);
    // Data presents a new request right after its ack: contention round B
    d_wea = 4'hF; d_addr = 32'h300; d_wdata = 32'hCAFE;
    tick();
    check("cb_gap", busy, 0);
    tick();
`ifdef MEM_ARB_RR_EN
    check("cb_wea", m_wea, 0);
    check("cb_wdata", m_wdata, 0);
    mem_serve(0, 1'b0, 32'h104, 32'h2222_2222);
    check("cb_ifack", if_ack, 1);
    check("cb_ifrd", if_rdata, 32'h2222_2222);
    if_req = 1'b0;
    tick(); tick();
    check("cc_wea", m_wea, 4'hF);
    mem_serve(0, 1'b0, 32'h300, 32'h3333_3333);
    check("cc_dack", d_ack, 1);
    check("cc_drd", d_rdata, 32'h3333_3333);
    d_req = 1'b0;
`else
    check("cb_wea", m_wea, 4'hF);
    check("cb_wdata", m_wdata, 32'hCAFE);
    mem_serve(0, 1'b0, 32'h300, 32'h2222_2222);
    check("cb_dack", d_ack, 1);
    check("cb_drd", d_rdata, 32'h2222_2222);
    d_req = 1'b0;
    tick(); tick();
    check("cc_wea", m_wea, 0);
    mem_serve(0, 1'b0, 32'h104, 32'h3333_3333);
    check("cc_ifack", if_ack, 1);
    check("cc_ifrd", if_rdata, 32'h3333_3333);
    if_req = 1'b0;
`endif
    tick();

    // Grant withheld 3 cycles, then gnt+rvalid together
    d_req = 1'b1; d_wea = 4'h0; d_addr = 32'h400; d_wdata = '0;
    tick();
    mem_serve(3, 1'b1, 32'h400, 32'h4444_4444);
    check("g_dack", d_ack, 1);
    check("g_drd", d_rdata, 32'h4444_4444);
    check("g_err", err, 0);
    d_req = 1'b0;
    tick();

    // Watchdog timeout: granted but never completed
    if_req = 1'b1; if_addr = 32'h500;
    tick();
    m_gnt = 1'b1; m_rdata = 32'hFFFF_FFFF;
    tick();
    m_gnt = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t_no_ack", if_ack, 0);
    end
    tick();
    check("t_ack", if_ack, 1);
    check("t_err", err, 1);
    check("t_rdata", if_rdata, 0);
    check("t_mreq", m_req, 0);
    if_req = 1'b0;
    tick();
    check("t_busy", busy, 0);
    check("t_err_clr", err, 0);

    // rvalid arriving in the timeout cycle completes normally
    if_req = 1'b1; if_addr = 32'h800;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    m_rvalid = 1'b1; m_rdata = 32'h8888_8888;
    tick();
    m_rvalid = 1'b0;
    check("tc_ack", if_ack, 1);
    check("tc_err", err, 0);
    check("tc_rdata", if_rdata, 32'h8888_8888);
    if_req = 1'b0;
    tick();

    // Reset during WAIT, then a late rvalid
    d_req = 1'b1; d_wea = 4'h0; d_addr = 32'h600;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; d_req = 1'b0;
    m_rvalid = 1'b1; m_rdata = 32'h6666_6666;
    check_all_zero("rst");
    tick();
    m_rvalid = 1'b0;
    check("rst_late_dack", d_ack, 0);
    check("rst_late_busy", busy, 0);
    check("rst_late_drd", d_rdata, 0);
    if_req = 1'b1; if_addr = 32'h700;
    tick();
    mem_serve(0, 1'b0, 32'h700, 32'h7777_7777);
    check("rst_next_ack", if_ack, 1);
    check("rst_next_rd", if_rdata, 32'h7777_7777);
    if_req = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
